// File: rtl/stage_sequencer.sv
// Multicycle IF/ID/EX/MEM/WB sequencer: holds IF/MEM on memory handshakes, issues IR/PC/RF
// write strobes, and stops the core on HALT or on a memory timeout (sticky bus_error).
module stage_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             is_halt,
  input  logic             mem_access,
  input  logic             reg_write,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             resume,
  output logic [2:0]       stage,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             rf_write,
  output logic             halted,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd7;

  // Counter only needs to reach TIMEOUT-1.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [2:0]        stage_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;
  logic              ready_sel;
  logic              timed_out;

  // Which handshake, if any, the current stage is waiting on.
  always_comb begin
    waiting   = 1'b0;
    ready_sel = 1'b0;
    case (stage)
      S_IF: begin
        waiting   = 1'b1;
        ready_sel = imem_ready;
      end
      S_MEM: begin
        waiting   = mem_access;
        ready_sel = dmem_ready;
      end
      default: ;
    endcase
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timed_out = 1'b0;
    end else begin : g_timeout
      assign timed_out = waiting && !ready_sel && (wait_cnt == WAIT_W'(TIMEOUT - 1));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage       <= S_IF;
      instr_count <= '0;
      bus_error   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      stage <= stage_next;
      if (timed_out)
        bus_error <= 1'b1;
      if (stage == S_WB)
        instr_count <= instr_count + CNT_W'(1);
      // Any state change restarts the wait count, so entry to IF/MEM starts at zero.
      if (stage_next != stage)
        wait_cnt <= '0;
      else if (waiting && !ready_sel)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    stage_next = stage;
    case (stage)
      S_IF: begin
        if (imem_ready)
          stage_next = S_ID;
        else if (timed_out)
          stage_next = S_HALT;
      end
      S_ID:  stage_next = is_halt ? S_HALT : S_EX;
      S_EX:  stage_next = S_MEM;
      S_MEM: begin
        if (!mem_access || dmem_ready)
          stage_next = S_WB;
        else if (timed_out)
          stage_next = S_HALT;
      end
      S_WB:  stage_next = S_IF;
      S_HALT: begin
        if (resume && !bus_error)
          stage_next = S_WB;
      end
      default: stage_next = S_IF;
    endcase
  end

  always_comb begin
    imem_req = (stage == S_IF);
    ir_write = (stage == S_IF) && imem_ready;
    dmem_req = (stage == S_MEM) && mem_access;
    pc_write = (stage == S_WB);
    rf_write = (stage == S_WB) && reg_write;
    halted   = (stage == S_HALT);
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: per-cycle reference model plus directed scenarios with literal expectations.
module tb_stage_sequencer;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             is_halt = 1'b0;
  logic             mem_access = 1'b0;
  logic             reg_write = 1'b1;
  logic             imem_ready = 1'b1;
  logic             dmem_ready = 1'b1;
  logic             resume = 1'b0;
  logic [2:0]       stage;
  logic             imem_req;
  logic             dmem_req;
  logic             ir_write;
  logic             pc_write;
  logic             rf_write;
  logic             halted;
  logic             bus_error;
  logic [CNT_W-1:0] instr_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .is_halt    (is_halt),
    .mem_access (mem_access),
    .reg_write  (reg_write),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .resume     (resume),
    .stage      (stage),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .rf_write   (rf_write),
    .halted     (halted),
    .bus_error  (bus_error),
    .instr_count(instr_count)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: stage number, unanswered request cycles, retired count, error flag.
  int m_stage, m_wait, m_cnt, m_nxt;
  bit m_berr, m_req, m_rdy;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("stage",       stage,       m_stage);
      check("imem_req",    imem_req,    m_stage == 0);
      check("ir_write",    ir_write,    (m_stage == 0) && imem_ready);
      check("dmem_req",    dmem_req,    (m_stage == 3) && mem_access);
      check("pc_write",    pc_write,    m_stage == 4);
      check("rf_write",    rf_write,    (m_stage == 4) && reg_write);
      check("halted",      halted,      m_stage == 7);
      check("bus_error",   bus_error,   m_berr);
      check("instr_count", instr_count, m_cnt);
    end
    // Inputs are stable from here to the next rising edge, so advance the model now.
    if (!reset) begin
      m_stage = 0; m_wait = 0; m_cnt = 0; m_berr = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_req = (m_stage == 0) || ((m_stage == 3) && mem_access);
      m_rdy = (m_stage == 0) ? imem_ready : dmem_ready;
      case (m_stage)
        0: m_nxt = 1;
        1: m_nxt = is_halt ? 7 : 2;
        2: m_nxt = 3;
        3: m_nxt = 4;
        4: begin m_nxt = 0; m_cnt = (m_cnt + 1) % (1 << CNT_W); end
        7: m_nxt = (resume && !m_berr) ? 4 : 7;
        default: m_nxt = 0;
      endcase
      if (m_req && !m_rdy) begin
        m_wait++;
        if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
          m_nxt  = 7;
          m_berr = 1;
        end else begin
          m_nxt = m_stage;
        end
      end
      if (m_nxt != m_stage) m_wait = 0;
      m_stage = m_nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_cnt[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset
    tick(); tick();
    check("rst_stage", stage, 0);
    check("rst_count", instr_count, 0);
    check("rst_berr", bus_error, 0);
    check("rst_halted", halted, 0);
    check("rst_imem_req", imem_req, 1);
    reset = 1'b1;

    // Zero-wait: 5 cycles per instruction
    for (int c = 1; c <= 15; c++) begin
      check("s1_stage", stage, (c - 1) % 5);
      check("s1_pc_write", pc_write, (c % 5 == 0) ? 1 : 0);
      check("s1_rf_write", rf_write, (c % 5 == 0) ? 1 : 0);
      tick();
    end
    check("s1_count", instr_count, 3);

    // imem wait of 3 cycles (just under the timeout)
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("s2_if_stage", stage, 0);
      check("s2_ir_low", ir_write, 0);
      check("s2_imem_req", imem_req, 1);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check("s2_ir_pulse", ir_write, 1);
    tick();
    check("s2_id_stage", stage, 1);
    check("s2_ir_after", ir_write, 0);
    check("s2_berr", bus_error, 0);
    tick(); tick(); tick(); tick();
    check("s2_wrap_count", instr_count, 0);
    check("s2_back_if", stage, 0);

    // dmem delayed 2 cycles: 7-cycle instruction
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    check("s3_dreq0", dmem_req, 1);
    tick();
    check("s3_dreq1", dmem_req, 1);
    check("s3_mem_hold", stage, 3);
    tick();
    dmem_ready = 1'b1;
    check("s3_dreq2", dmem_req, 1);
    tick();
    check("s3_wb", stage, 4);
    check("s3_pc", pc_write, 1);
    check("s3_dreq_off", dmem_req, 0);
    tick();
    check("s3_if", stage, 0);
    check("s3_count", instr_count, 1);
    mem_access = 1'b0;

    // HALT then resume
    is_halt = 1'b1;
    tick(); tick();
    check("s4_halt_stage", stage, 7);
    check("s4_halted", halted, 1);
    check("s4_no_pc", pc_write, 0);
    check("s4_count_held", instr_count, 1);
    is_halt = 1'b0;
    tick();
    check("s4_stay", stage, 7);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("s4_wb", stage, 4);
    check("s4_pc", pc_write, 1);
    tick();
    check("s4_if", stage, 0);
    check("s4_count", instr_count, 2);

    // dmem timeout
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      check("s5_dreq", dmem_req, 1);
      check("s5_mem", stage, 3);
      tick();
    end
    check("s5_halt", stage, 7);
    check("s5_berr", bus_error, 1);
    check("s5_halted", halted, 1);
    resume = 1'b1;
    tick(); tick();
    check("s5_resume_ignored", stage, 7);
    resume = 1'b0;
    reset = 1'b0;
    tick();
    check("s5_rst_stage", stage, 0);
    check("s5_rst_berr", bus_error, 0);
    check("s5_rst_count", instr_count, 0);
    reset = 1'b1; mem_access = 1'b0; dmem_ready = 1'b1;

    // imem timeout
    imem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    check("s6_halt", stage, 7);
    check("s6_berr", bus_error, 1);
    imem_ready = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;

    // Counter wrap at CNT_W=2
    for (int i = 0; i < 5; i++) begin
      repeat (5) tick();
      check("s7_count", instr_count, exp_cnt[i]);
      check("s7_stage", stage, 0);
    end

    // Reset in the middle of a dmem wait
    mem_access = 1'b1; dmem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    check("s8_mem_wait", stage, 3);
    reset = 1'b0;
    tick();
    check("s8_rst_stage", stage, 0);
    check("s8_rst_count", instr_count, 0);
    reset = 1'b1; mem_access = 1'b0; dmem_ready = 1'b1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
